// File: rtl/dmem_access.sv
// Memory-access stage: issues loads/stores on the data SRAM req/ack bus and registers results for writeback.
// Latency: 1 cycle for non-memory or misaligned ops; ack cycle + 1 for bus ops. Optional DMEM_ALIGN_CHECK_EN enables misalignment traps.
// Backpressure: in_ready is low while a bus op is outstanding; writeback never stalls this stage.
module dmem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_memtoreg,
    input  logic [3:0]        in_memwrite,
    input  logic              in_lu,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [31:0]       in_result,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_ack,
    input  logic [31:0]       data_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_result,
    output logic [31:0]       wb_rdata,
    output logic [3:0]        wb_memtoreg,
    output logic [1:0]        wb_offset,
    output logic              wb_lu,
    output logic              wb_adel,
    output logic              wb_ades
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        fire, is_load, is_store, misaligned, go_bus, ack_fire;
    logic [3:0]  lane, strb;
    logic [31:0] wdat;

    logic [31:0] p_result;
    logic [3:0]  p_memtoreg;
    logic [1:0]  p_offset;
    logic        p_lu, p_store;

    assign in_ready = (state == IDLE);
    assign fire     = in_valid && in_ready;
    assign ack_fire = (state == BUSY) && data_ack;
    // A load mask wins when both masks are set; the store is dropped.
    assign is_load  = |in_memtoreg;
    assign is_store = !is_load && (|in_memwrite);
    assign lane     = is_load ? in_memtoreg : in_memwrite;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((lane == 4'b0011) && in_addr[0]) ||
                        ((lane == 4'b1111) && (in_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign go_bus = (is_load || is_store) && !misaligned;

    always_comb begin
        strb = 4'b1111;
        wdat = in_wdata;
        case (in_memwrite)
            4'b0001: begin
                strb = 4'b0001 << in_addr[1:0];
                wdat = {4{in_wdata[7:0]}};
            end
            4'b0011: begin
                strb = 4'b0011 << {in_addr[1], 1'b0};
                wdat = {2{in_wdata[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                wdat = in_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire && go_bus) state_nxt = BUSY;
            BUSY:    if (data_ack)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus signals are registered at accept and held untouched until the ack edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_addr  <= '0;
            data_wstrb <= 4'b0000;
            data_wdata <= '0;
            p_result   <= '0;
            p_memtoreg <= 4'b0000;
            p_offset   <= 2'b00;
            p_lu       <= 1'b0;
            p_store    <= 1'b0;
        end else if (fire && go_bus) begin
            data_req   <= 1'b1;
            data_wr    <= is_store;
            data_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
            data_wstrb <= is_store ? strb : 4'b0000;
            data_wdata <= is_store ? wdat : 32'h0;
            p_result   <= in_result;
            p_memtoreg <= in_memtoreg;
            p_offset   <= in_addr[1:0];
            p_lu       <= in_lu;
            p_store    <= is_store;
        end else if (ack_fire) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_wstrb <= 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid    <= 1'b0;
            wb_result   <= '0;
            wb_rdata    <= '0;
            wb_memtoreg <= 4'b0000;
            wb_offset   <= 2'b00;
            wb_lu       <= 1'b0;
            wb_adel     <= 1'b0;
            wb_ades     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (fire && !go_bus) begin
                wb_valid    <= 1'b1;
                wb_result   <= in_result;
                wb_rdata    <= '0;
                wb_memtoreg <= misaligned ? 4'b0000 : in_memtoreg;
                wb_offset   <= in_addr[1:0];
                wb_lu       <= in_lu;
                wb_adel     <= is_load && misaligned;
                wb_ades     <= is_store && misaligned;
            end else if (ack_fire) begin
                wb_valid    <= 1'b1;
                wb_result   <= p_result;
                wb_rdata    <= p_store ? 32'h0 : data_rdata;
                wb_memtoreg <= p_memtoreg;
                wb_offset   <= p_offset;
                wb_lu       <= p_lu;
                wb_adel     <= 1'b0;
                wb_ades     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dmem_access.md
Name: dmem_access

Overview:
- Memory-access stage sitting directly upstream of the writeback load mux.
- Accepts one instruction at a time from the execute stage and issues loads/stores to the data SRAM bus over a req/ack handshake.
- Stores: generates byte strobes and replicated write data.
- Loads: registers the raw 32-bit read word plus memtoreg/offset/lu so writeback can do lane extraction and sign/zero extension.

Parameters:
- ADDR_W, 32, data bus address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present from execute.
- in_ready  out  1  stage can accept; upstream stalls when low.
- in_memtoreg  in  4  load lane mask: 0000 none, 0001 byte, 0011 half, 1111 word.
- in_memwrite  in  4  store lane mask, same encoding; 0000 no store.
- in_lu  in  1  unsigned load.
- in_addr  in  32  effective address.
- in_wdata  in  32  store data in low lanes.
- in_result  in  32  ALU result passed to writeback.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_addr  out  ADDR_W  word-aligned address, low 2 bits 00.
- data_wstrb  out  4  byte strobes; 0000 on reads.
- data_wdata  out  32  store data.
- data_ack  in  1  bus completion; data_rdata valid same cycle.
- data_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_result  out  32  registered in_result.
- wb_rdata  out  32  registered read word.
- wb_memtoreg  out  4  registered load mask; forced 0000 on exception.
- wb_offset  out  2  registered in_addr[1:0].
- wb_lu  out  1  registered lu.
- wb_adel  out  1  load address misaligned.
- wb_ades  out  1  store address misaligned.

Behaviour:
- Reset (async, resetn low): state IDLE. data_req, data_wr, data_wstrb, wb_valid, wb_adel, wb_ades = 0. All other wb_* and data_* = 0.
- in_ready = (state == IDLE). Transfer occurs when in_valid && in_ready.
- Memory op: in_memtoreg != 0 (load) or in_memwrite != 0 (store). Both nonzero is illegal; treated as load, store ignored.
- Misaligned:
  - half: addr[0] = 1.
  - word: addr[1:0] != 00.
  - byte: never misaligned.
- IDLE, transfer of non-memory op or misaligned memory op:
  - Next edge: wb_valid = 1, wb_* loaded, no bus activity. Latency 1.
  - Misaligned load: wb_adel = 1 and wb_memtoreg = 0000.
  - Misaligned store: wb_ades = 1.
- IDLE, transfer of aligned memory op: next edge enter BUSY; data_req = 1 and all data_* registered and held stable until ack.
  - Byte store: data_wstrb = 0001 << addr[1:0]; data_wdata = {4{wdata[7:0]}}.
  - Half store: data_wstrb = 0011 << {addr[1], 0}; data_wdata = {2{wdata[15:0]}}.
  - Word store: data_wstrb = 1111; data_wdata = wdata.
  - Load: data_wr = 0, data_wstrb = 0000.
- BUSY: hold until data_ack sampled high, for any number of cycles.
  - On the ack edge: data_req drops to 0, state returns to IDLE, wb_valid = 1, wb_rdata = data_rdata (stores: wb_rdata = 0). Other wb_* come from the captured instruction.
  - Load latency = ack cycle + 1.
  - data_ack outside BUSY is ignored.
- wb_valid is low on every cycle without a retirement. wb_* other than wb_valid hold their last value.
- No backpressure from writeback.
- Reset mid-BUSY: request abandoned immediately (data_req = 0); nothing retires.
- Throughput: one memory op per (2 + wait) cycles minimum; one non-memory op per cycle.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: misalignment detection, wb_adel and wb_ades as specified above.
- Undefined:
  - wb_adel and wb_ades are tied 0 and every memory op goes to the bus.
  - Strobes use the shift formulas above. Half strobe uses addr[1] only; word strobe is 1111.
  - wb_offset still carries the raw addr[1:0].

Test Plan:
- Reset mid-operation: resetn low while BUSY -> data_req = 0 same cycle; no wb_valid after release; first subsequent op retires normally.
- Non-memory op, in_result = 0x12345678 -> next cycle wb_valid = 1, wb_result = 0x12345678, wb_memtoreg = 0000, data_req never asserted.
- sb, addr = 0x1003, wdata = 0x000000AB, ack after 3 wait cycles -> data_addr = 0x1000, data_wstrb = 1000, data_wdata = 0xABABABAB held stable; in_ready low until return to IDLE; one wb_valid pulse.
- lh, addr = 0x2002, lu = 0, data_rdata = 0x8001FFFF at ack -> wb_rdata = 0x8001FFFF, wb_offset = 10, wb_memtoreg = 0011, wb_lu = 0 on the cycle after ack.
- lw, addr = 0x2001 with DMEM_ALIGN_CHECK_EN -> no data_req, wb_adel = 1, wb_memtoreg = 0000 after 1 cycle. Without the macro -> bus read at 0x2000, wb_adel = 0.
- Back-to-back: sw followed by a non-memory op held at input -> second op accepted only after sw retires; two wb_valid pulses, no duplicate bus request.
